// File: rtl/div_defs.sv
// Shared definitions for the restoring divider.
// Holds the FSM state encoding and the quotient value returned on a
// divide-by-zero request, sized from the divider's WIDTH parameter.
package div_defs;

  // Widest operand the divider supports; sizes the constant helper below.
  localparam int MAX_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  // All-ones quotient of width w, right-aligned in a MAX_WIDTH vector.
  // The extra top bit keeps w == MAX_WIDTH from shifting the one out.
  function automatic logic [MAX_WIDTH-1:0] dbz_quotient(input int unsigned w);
    logic [MAX_WIDTH:0] ones_v;
    ones_v = ({{MAX_WIDTH{1'b0}}, 1'b1} << w) - {{MAX_WIDTH{1'b0}}, 1'b1};
    return ones_v[MAX_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/restoring_div_step.sv
// One restoring-division step (purely combinational).
// Shifts the next dividend bit into the partial remainder, trial-subtracts
// the divisor and keeps the difference only when it did not go negative.
// Ports:
//   rem_in   - current partial remainder (always < divisor)
//   bit_in   - next dividend bit, MSB first
//   divisor  - unsigned divisor
//   rem_out  - partial remainder after this step
//   q_bit    - quotient bit produced by this step
module restoring_div_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] trial_s;
  logic [WIDTH:0] diff_s;

  // The subtraction is one bit wider than the operands so its MSB is a
  // true borrow. Whichever value is kept is below the divisor, so its top
  // bit is always zero and only the low WIDTH bits are carried forward.
  always_comb begin
    trial_s = {rem_in, bit_in};
    diff_s  = trial_s - {1'b0, divisor};
    if (diff_s[WIDTH] == 1'b0) begin
      q_bit   = 1'b1;
      rem_out = diff_s[WIDTH-1:0];
    end else begin
      q_bit   = 1'b0;
      rem_out = trial_s[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/restoring_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Ports:
//   clk, rst_n   - rising-edge clock, asynchronous active-low reset
//   start        - request, only honoured while idle
//   dividend     - unsigned dividend, captured on an accepted start
//   divisor      - unsigned divisor, captured on an accepted start
//   busy         - high while a request is running or completing
//   done         - one-cycle completion pulse
//   quotient     - registered quotient (all ones on divide by zero)
//   remainder    - registered remainder (dividend on divide by zero)
//   div_by_zero  - registered; last accepted divisor was zero
module restoring_divider
  import div_defs::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [MAX_WIDTH-1:0] DBZ_FULL = dbz_quotient(WIDTH);
  localparam logic [WIDTH-1:0]     DBZ_QUOT = DBZ_FULL[WIDTH-1:0];

  div_state_e       state_r;
  div_state_e       state_next_s;
  logic [CW-1:0]    count_r;
  logic [WIDTH-1:0] divisor_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] step_rem_s;
  logic             step_qbit_s;
  logic [WIDTH-1:0] q_next_s;
  logic             last_step_s;
  logic             accept_s;
  logic             zero_div_s;

  restoring_div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_in (rem_r),
    .bit_in (q_r[WIDTH-1]),
    .divisor(divisor_r),
    .rem_out(step_rem_s),
    .q_bit  (step_qbit_s)
  );

  // Decode helpers shared by the FSM and the datapath.
  always_comb begin
    q_next_s    = {q_r[WIDTH-2:0], step_qbit_s};
    last_step_s = (count_r == CW'(1));
    accept_s    = (state_r == ST_IDLE) && start;
    zero_div_s  = (divisor == {WIDTH{1'b0}});
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (zero_div_s) begin
            state_next_s = ST_DONE;
          end else begin
            state_next_s = ST_RUN;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_step_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register; busy and done are registered from the next state so
  // they line up exactly with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy    <= (state_next_s != ST_IDLE);
      done    <= (state_next_s == ST_DONE);
    end
  end

  // Iteration datapath and result registers. Results only move on a
  // zero-divisor accept or on the final RUN step, so they hold during RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r     <= {CW{1'b0}};
      divisor_r   <= {WIDTH{1'b0}};
      rem_r       <= {WIDTH{1'b0}};
      q_r         <= {WIDTH{1'b0}};
      quotient    <= {WIDTH{1'b0}};
      remainder   <= {WIDTH{1'b0}};
      div_by_zero <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            if (zero_div_s) begin
              quotient    <= DBZ_QUOT;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              divisor_r   <= divisor;
              rem_r       <= {WIDTH{1'b0}};
              q_r         <= dividend;
              count_r     <= CW'(WIDTH);
              div_by_zero <= 1'b0;
            end
          end else begin
            count_r <= count_r;
          end
        end
        ST_RUN: begin
          rem_r   <= step_rem_s;
          q_r     <= q_next_s;
          count_r <= count_r - CW'(1);
          if (last_step_s) begin
            quotient  <= q_next_s;
            remainder <= step_rem_s;
          end else begin
            quotient  <= quotient;
          end
        end
        ST_DONE: count_r <= count_r;
        default: count_r <= {CW{1'b0}};
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_divider.sv
// Directed self-checking bench for restoring_divider at WIDTH = 4.
module tb_restoring_divider;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int tests_run;
  int tests_failed;

  restoring_divider #(
    .WIDTH(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called just after the acceptance edge; returns edges until done is seen
  // and how many sampled cycles had busy high (including the done cycle).
  task automatic wait_done(output int edges, output int busy_n);
    edges  = 0;
    busy_n = 0;
    while (!done && edges < 40) begin
      busy_n += int'(busy);
      @(posedge clk); #1;
      edges++;
    end
    busy_n += int'(busy);
    check("done_seen", {31'd0, done}, 32'd1);
  endtask

  // One complete request from idle; start is dropped after acceptance.
  task automatic do_div(input logic [3:0] a, input logic [3:0] b,
                        output int edges, output int busy_n);
    @(posedge clk); #1;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(edges, busy_n);
  endtask

  initial begin
    int edges;
    int busy_n;
    int pulses;
    logic [3:0] cap_q;
    logic [3:0] cap_r;
    logic [3:0] exp_q;
    logic [3:0] exp_r;

    tests_run    = 0;
    tests_failed = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = 4'd0;
    divisor  = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_quot", {28'd0, quotient}, 32'd0);
    check("rst_rem",  {28'd0, remainder}, 32'd0);
    check("rst_dbz",  {31'd0, div_by_zero}, 32'd0);
    rst_n = 1'b1;

    // 13 / 3 = 4 r 1, done four edges after acceptance, busy for 5 cycles.
    do_div(4'd13, 4'd3, edges, busy_n);
    check("d13_3_lat",  edges, 32'd4);
    check("d13_3_busy", busy_n, 32'd5);
    check("d13_3_q",    {28'd0, quotient}, 32'd4);
    check("d13_3_r",    {28'd0, remainder}, 32'd1);
    check("d13_3_dbz",  {31'd0, div_by_zero}, 32'd0);
    @(posedge clk); #1;
    check("d13_3_idle", {31'd0, busy}, 32'd0);

    // Back-to-back with start held high: 2/9 then 15/1.
    @(posedge clk); #1;
    start    = 1'b1;
    dividend = 4'd2;
    divisor  = 4'd9;
    @(posedge clk); #1;
    dividend = 4'd15;
    divisor  = 4'd1;
    wait_done(edges, busy_n);
    check("b2b_first_q", {28'd0, quotient}, 32'd0);
    check("b2b_first_r", {28'd0, remainder}, 32'd2);
    @(posedge clk); #1;
    check("b2b_gap_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    check("b2b_accept_busy", {31'd0, busy}, 32'd1);
    start = 1'b0;
    wait_done(edges, busy_n);
    check("b2b_second_lat", edges, 32'd4);
    check("b2b_second_q", {28'd0, quotient}, 32'd15);
    check("b2b_second_r", {28'd0, remainder}, 32'd0);

    // 7 / 0: done right after acceptance, all-ones quotient.
    do_div(4'd7, 4'd0, edges, busy_n);
    check("dz_lat", edges, 32'd0);
    check("dz_q",   {28'd0, quotient}, 32'd15);
    check("dz_r",   {28'd0, remainder}, 32'd7);
    check("dz_dbz", {31'd0, div_by_zero}, 32'd1);
    do_div(4'd8, 4'd2, edges, busy_n);
    check("d8_2_q",   {28'd0, quotient}, 32'd4);
    check("d8_2_r",   {28'd0, remainder}, 32'd0);
    check("d8_2_dbz", {31'd0, div_by_zero}, 32'd0);

    // 12 / 5 with a 3 / 1 request raised mid-run that must be ignored.
    @(posedge clk); #1;
    start    = 1'b1;
    dividend = 4'd12;
    divisor  = 4'd5;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start    = 1'b1;
    dividend = 4'd3;
    divisor  = 4'd1;
    check("ign_hold_q", {28'd0, quotient}, 32'd4);
    @(posedge clk); #1;
    start  = 1'b0;
    pulses = 0;
    cap_q  = 4'd0;
    cap_r  = 4'd0;
    for (int i = 0; i < 12; i++) begin
      if (done) begin
        pulses++;
        cap_q = quotient;
        cap_r = remainder;
      end
      @(posedge clk); #1;
    end
    check("ign_pulses", pulses, 32'd1);
    check("ign_q", {28'd0, cap_q}, 32'd2);
    check("ign_r", {28'd0, cap_r}, 32'd2);

    // Reset during the second RUN cycle of 14 / 3.
    @(posedge clk); #1;
    start    = 1'b1;
    dividend = 4'd14;
    divisor  = 4'd3;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_q",    {28'd0, quotient}, 32'd0);
    check("abort_r",    {28'd0, remainder}, 32'd0);
    check("abort_dbz",  {31'd0, div_by_zero}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check("abort_no_done", pulses, 32'd0);
    do_div(4'd14, 4'd3, edges, busy_n);
    check("d14_3_lat", edges, 32'd4);
    check("d14_3_q", {28'd0, quotient}, 32'd4);
    check("d14_3_r", {28'd0, remainder}, 32'd2);

    // Exhaustive sweep of every operand pair.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        do_div(a[3:0], b[3:0], edges, busy_n);
        if (b == 0) begin
          exp_q = 4'd15;
          exp_r = a[3:0];
        end else begin
          exp_q = 4'(a / b);
          exp_r = 4'(a % b);
        end
        check($sformatf("sweep_q_%0d_%0d", a, b), {28'd0, quotient}, {28'd0, exp_q});
        check($sformatf("sweep_r_%0d_%0d", a, b), {28'd0, remainder}, {28'd0, exp_r});
        check($sformatf("sweep_z_%0d_%0d", a, b), {31'd0, div_by_zero},
              (b == 0) ? 32'd1 : 32'd0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/restoring_divider.md
Name: restoring_divider

Overview:
- Multi-cycle unsigned integer divider built on trial subtraction, the inverse of the team's adder datapath.
- Accepts a dividend/divisor pair with a start pulse.
- Iterates one quotient bit per clock.
- Returns quotient, remainder and a divide-by-zero flag with a one-cycle done pulse.
- Sits beside the adder blocks as the arithmetic unit for lab-level datapaths.

Parameters:
- WIDTH, 4, operand/quotient/remainder width in bits (legal range 2..16).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only while idle
- dividend  input  WIDTH  unsigned dividend, sampled on accepted start
- divisor  input  WIDTH  unsigned divisor, sampled on accepted start
- busy  output  1  high from the cycle after start is accepted until done deasserts
- done  output  1  one-cycle pulse; results valid from this cycle on
- quotient  output  WIDTH  registered quotient
- remainder  output  WIDTH  registered remainder
- div_by_zero  output  1  registered; high when the last accepted divisor was 0

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE. busy, done, quotient, remainder and div_by_zero all 0. Internal counters cleared.
- Reset mid-operation aborts immediately. No done pulse is produced for the aborted request.
- States: IDLE, RUN, DONE. Encoding is binary, defined in the shared package.
- IDLE, start=1 at edge k, divisor!=0:
  - Latch divisor.
  - Load remainder register R=0 (WIDTH+1 bits) and quotient shift register Q=dividend.
  - Set count=WIDTH, clear div_by_zero, go to RUN.
- IDLE, start=1 at edge k, divisor==0:
  - quotient <= all ones, remainder <= dividend, div_by_zero <= 1.
  - Go to DONE. done is high in the cycle after edge k.
- RUN, each edge:
  - T = {R[WIDTH-1:0], Q[WIDTH-1]}.
  - D = T - {1'b0, divisor}, computed in WIDTH+1 bits.
  - If D is non-negative (MSB=0): R<=D, Q<={Q[WIDTH-2:0],1}. Else: R<=T, Q<={Q[WIDTH-2:0],0}.
  - count decrements. At the edge where count goes 1->0, quotient<=new Q, remainder<=new R[WIDTH-1:0], and state goes to DONE.
- Latency: with start accepted at edge k, done is high in the cycle following edge k+WIDTH, i.e. WIDTH cycles for nonzero divisors and 1 cycle for zero divisors.
- DONE: done=1 for exactly one cycle, then return to IDLE at the next edge. busy=1 in RUN and DONE, 0 in IDLE.
- start while RUN or DONE is ignored; operands are not resampled. start is level-sampled, so start held high re-triggers at the first IDLE cycle after DONE.
- quotient, remainder and div_by_zero hold their values until the next accepted start completes or reset occurs. They do not change during RUN.
- Invariant on completion, for divisor!=0: quotient*divisor + remainder == dividend, and remainder < divisor.
- All arithmetic is unsigned. The trial subtraction must be WIDTH+1 bits wide so that no borrow is lost.

Decomposition:
- Shared package/header div_defs:
  - State constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - The divide-by-zero quotient constant (all ones, width-parameterised).
- One sub-module, restoring_div_step (combinational):
  - Inputs: partial remainder, incoming bit, divisor.
  - Outputs: next remainder and quotient bit.
  - Verifiable standalone against the subtract-and-compare rule.
- Top level holds the FSM, counter and registers.

Test Plan (WIDTH=4):
- Reset then start with dividend=13, divisor=3 -> done 4 cycles after the start edge; quotient=4, remainder=1, div_by_zero=0, busy high for 5 cycles.
- dividend=2, divisor=9, then dividend=15, divisor=1 back-to-back -> quotient=0, remainder=2, then quotient=15, remainder=0. The second start is accepted only in the IDLE cycle after the first done.
- dividend=7, divisor=0 -> done 1 cycle after start; quotient=15, remainder=7, div_by_zero=1. A following 8/2 request clears div_by_zero and gives quotient=4, remainder=0.
- Start 12/5, then assert start with 3/1 two cycles later (during RUN) -> second request ignored; result quotient=2, remainder=2; exactly one done pulse.
- Start 14/3, pull rst_n low in the 2nd RUN cycle -> all outputs 0 immediately, no done. After release, 14/3 yields quotient=4, remainder=2.
- Exhaustive sweep of all 256 dividend/divisor pairs -> for divisor!=0, quotient=dividend/divisor and remainder=dividend%divisor; for divisor==0, div_by_zero=1. The error counter must end at 0.
